// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the binary clock display path: segment
// patterns (active-low {g,f,e,d,c,b,a}), digit index, view mode, time snapshot.
package clock_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        VIEW_HHMM = 1'b0,
        VIEW_MMSS = 1'b1
    } view_mode_t;

    typedef struct packed {
        logic [3:0] hr_10s;
        logic [3:0] hr_1s;
        logic [3:0] min_10s;
        logic [3:0] min_1s;
        logic [3:0] sec_10s;
        logic [3:0] sec_1s;
    } bcd_time_t;

    // Matches the clock core's 12:00:00 power-on time.
    localparam bcd_time_t TIME_RESET = bcd_time_t'(24'h120000);

    // Digit shown at position i (0 = rightmost) for the given view.
    function automatic logic [3:0] view_digit(bcd_time_t t, view_mode_t m, digit_idx_t i);
        logic [3:0] d;
        if (m == VIEW_HHMM) begin
            case (i)
                2'd0:    d = t.min_1s;
                2'd1:    d = t.min_10s;
                2'd2:    d = t.hr_1s;
                default: d = t.hr_10s;
            endcase
        end else begin
            case (i)
                2'd0:    d = t.sec_1s;
                2'd1:    d = t.sec_10s;
                2'd2:    d = t.min_1s;
                default: d = t.min_10s;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// BCD time bus from the clock core to the display scanner.
interface bcd_display_scan_if;
    logic [3:0] sec_1s;
    logic [3:0] sec_10s;
    logic [3:0] min_1s;
    logic [3:0] min_10s;
    logic [3:0] hr_1s;
    logic [3:0] hr_10s;

    modport master (output sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s);
    modport slave  (input  sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 blank.
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit common-anode scanner showing HH:MM or MM:SS (debounced mode button).
// Define DP_BLINK_EN to blink the colon with tick_1Hz; otherwise the colon is steady.
module bcd_display_scan
    import clock_disp_pkg::*;
#(
    parameter int DIGIT_PERIOD = 100_000,
    parameter int GUARD_CYCLES = 16,
    parameter int DB_CYCLES    = 1_000_000
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               tick_1Hz,
    bcd_display_scan_if.slave  tm,
    input  logic               mode_btn,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic               mode
);

    localparam int DWELL_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DIGIT_PERIOD - 1);
    localparam logic [DWELL_W-1:0] GUARD_END  = DWELL_W'(GUARD_CYCLES);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);

    logic [DWELL_W-1:0] dwell_q, dwell_d;
    digit_idx_t         idx_q, idx_d;
    bcd_time_t          snap_q;
    view_mode_t         mode_q, pend_q;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               dwell_last, frame_end, guard, lz_blank, colon;
    logic [3:0]         cur_bcd;
    logic [6:0]         cur_seg;

    logic               btn_meta_q, btn_sync_q, db_state_q;
    logic [DB_W-1:0]    db_cnt_q;

`ifdef DP_BLINK_EN
    logic tick_q;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) tick_q <= 1'b0;
        else       tick_q <= tick_1Hz;
    end

    assign colon = ~tick_q;
`else
    logic unused_tick;
    assign unused_tick = tick_1Hz;
    assign colon       = 1'b0;
`endif

    assign dwell_last = (dwell_q == DWELL_LAST);
    assign frame_end  = dwell_last && (idx_q == 2'd3);
    assign dwell_d    = dwell_last ? '0 : dwell_q + 1'b1;
    assign idx_d      = dwell_last ? idx_q + 2'd1 : idx_q;

    assign cur_bcd = view_digit(snap_q, mode_q, idx_q);

    bcd_to_seg7 u_dec (
        .bcd_i (cur_bcd),
        .seg_o (cur_seg)
    );

    always_comb begin
        guard    = (dwell_q < GUARD_END);
        lz_blank = (mode_q == VIEW_HHMM) && (idx_q == 2'd3) && (snap_q.hr_10s == 4'd0);
        an_d     = 4'b1111;
        if (!guard && !lz_blank) an_d[idx_q] = 1'b0;
        seg_d    = cur_seg;
        dp_d     = 1'b1;
        if (idx_q == 2'd2 && !guard) dp_d = colon;
    end

    // Snapshot and view switch only at the frame boundary so a frame never tears.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            dwell_q <= '0;
            idx_q   <= '0;
            snap_q  <= TIME_RESET;
            mode_q  <= VIEW_HHMM;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            if (frame_end) begin
                snap_q <= '{hr_10s: tm.hr_10s, hr_1s: tm.hr_1s,
                            min_10s: tm.min_10s, min_1s: tm.min_1s,
                            sec_10s: tm.sec_10s, sec_1s: tm.sec_1s};
                mode_q <= pend_q;
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            db_state_q <= 1'b0;
            db_cnt_q   <= '0;
            pend_q     <= VIEW_HHMM;
        end else begin
            btn_meta_q <= mode_btn;
            btn_sync_q <= btn_meta_q;
            if (btn_sync_q == db_state_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_state_q <= btn_sync_q;
                db_cnt_q   <= '0;
                if (btn_sync_q) pend_q <= (pend_q == VIEW_HHMM) ? VIEW_MMSS : VIEW_HHMM;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: per-cycle reference model plus directed literal checks.
module tb_bcd_display_scan;

    localparam int P  = 8;
    localparam int G  = 2;
    localparam int DB = 4;
    localparam int FR = 4 * P;
`ifdef DP_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    localparam logic [6:0] SEGTAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                           7'b0000000, 7'b0010000};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b1;
    logic       btn = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, mode;

    int checks = 0;
    int errors = 0;

    bcd_display_scan_if tm_if();

    bcd_display_scan #(.DIGIT_PERIOD(P), .GUARD_CYCLES(G), .DB_CYCLES(DB)) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .tick_1Hz   (tick),
        .tm         (tm_if),
        .mode_btn   (btn),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    // Reference model: time as an array {sec1,sec10,min1,min10,hr1,hr10}.
    int         m_n = 0;
    bit         m_mode = 0, m_pend = 0, m_db = 0, prev_tick = 0;
    int         snap [6] = '{0, 0, 0, 0, 2, 1};
    bit         hist [4096];
    logic [3:0] exp_an = 4'hF;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp = 1'b1, exp_mode = 1'b0;
    int         dw, ix, v, wi;
    bit         guard, lz, all_new, ws;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n = 0; m_mode = 0; m_pend = 0; m_db = 0; prev_tick = 0;
            snap = '{0, 0, 0, 0, 2, 1};
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_mode = 1'b0;
        end else begin
            dw    = m_n % P;
            ix    = (m_n / P) % 4;
            v     = snap[ix + (m_mode ? 0 : 2)];
            guard = (dw < G);
            lz    = !m_mode && ix == 3 && snap[5] == 0;
            exp_an = 4'hF;
            if (!guard && !lz) exp_an[ix] = 1'b0;
            if (v < 10) exp_seg = SEGTAB[v];
            else        exp_seg = 7'h7F;
            exp_dp = (ix == 2 && !guard) ? (BLINK ? !prev_tick : 1'b0) : 1'b1;
            if (m_n % FR == FR - 1) begin
                snap = '{int'(tm_if.sec_1s), int'(tm_if.sec_10s), int'(tm_if.min_1s),
                         int'(tm_if.min_10s), int'(tm_if.hr_1s), int'(tm_if.hr_10s)};
                m_mode = m_pend;
            end
            exp_mode = m_mode;
            // Debounced level flips once DB consecutive synchronised samples disagree with it.
            all_new = 1;
            for (int k = 0; k < DB; k++) begin
                wi = m_n - 2 - k;
                ws = (wi >= 0) ? hist[wi % 4096] : 1'b0;
                if (ws == m_db) all_new = 0;
            end
            if (all_new) begin
                m_db = !m_db;
                if (m_db) m_pend = !m_pend;
            end
            hist[m_n % 4096] = btn;
            prev_tick = tick;
            m_n++;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_an", 8'(an), 8'(exp_an));
        chk("model_seg", 8'(seg), 8'(exp_seg));
        chk("model_dp", 8'(dp), 8'(exp_dp));
        chk("model_mode", 8'(mode), 8'(exp_mode));
    end

    task automatic goto(input int n);
        int budget = 2000;
        while (m_n <= n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (m_n <= n) begin
            checks++; errors++;
            $display("FAIL goto_timeout: reached edge %0d, expected edge %0d", m_n, n + 1);
        end
    endtask

    task automatic set_time(input int h10, h1, m10, m1, s10, s1);
        tm_if.hr_10s = 4'(h10); tm_if.hr_1s = 4'(h1);
        tm_if.min_10s = 4'(m10); tm_if.min_1s = 4'(m1);
        tm_if.sec_10s = 4'(s10); tm_if.sec_1s = 4'(s1);
    endtask

    initial begin
        set_time(1, 2, 3, 4, 5, 6);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_an", 8'(an), 8'hF);
        chk("rst_seg", 8'(seg), 8'h7F);
        chk("rst_dp", 8'(dp), 8'h1);
        chk("rst_mode", 8'(mode), 8'h0);
        reset = 1'b0;

        // Frame 0: reset snapshot 12:00
        goto(1);  chk("guard_an", 8'(an), 8'b1111);
        goto(2);  chk("f0_d0_an", 8'(an), 8'b1110); chk("f0_d0_seg", 8'(seg), 8'b1000000);
        goto(10); chk("f0_d1_an", 8'(an), 8'b1101); chk("f0_d1_dp", 8'(dp), 8'h1);
        goto(18); chk("f0_d2_seg", 8'(seg), 8'b0100100); chk("f0_d2_dp_tick1", 8'(dp), 8'h0);
        goto(26); chk("f0_d3_an", 8'(an), 8'b0111); chk("f0_d3_seg", 8'(seg), 8'b1111001);
        // Frame 1: captured 12:34:56
        goto(34); chk("f1_d0_an", 8'(an), 8'b1110); chk("f1_d0_seg", 8'(seg), 8'b0011001);
        goto(42); chk("f1_d1_seg", 8'(seg), 8'b0110000);
        goto(50); chk("f1_d2_seg", 8'(seg), 8'b0100100);
        goto(58); chk("f1_d3_seg", 8'(seg), 8'b1111001);

        // Hours 09 captured at edge 63, then invalid min_1s captured at edge 95
        set_time(0, 9, 3, 4, 5, 6);
        goto(82); chk("lz_d2_an", 8'(an), 8'b1011); chk("lz_d2_seg", 8'(seg), 8'b0010000);
        tm_if.min_1s = 4'hA;
        for (int e = 88; e < 96; e++) begin
            goto(e); chk("lz_d3_an", 8'(an), 8'b1111);
        end
        goto(98); chk("badbcd_seg", 8'(seg), 8'h7F); chk("badbcd_an", 8'(an), 8'b1110);
        chk("d0_dp", 8'(dp), 8'h1);
        goto(111); tick = 1'b0;
        goto(114); chk("d2_dp_tick0", 8'(dp), BLINK ? 8'h1 : 8'h0);
        goto(120); tick = 1'b1; tm_if.min_1s = 4'd4;

        // Mode button: short pulse rejected, long hold accepted at next boundary
        goto(129); btn = 1'b1;
        goto(131); btn = 1'b0;
        goto(160); chk("pulse_mode", 8'(mode), 8'h0);
        goto(163); btn = 1'b1;
        goto(173); btn = 1'b0;
        goto(190); chk("hold_mode_pre", 8'(mode), 8'h0);
        goto(191); chk("hold_mode_post", 8'(mode), 8'h1);
        goto(194); chk("mmss_d0_seg", 8'(seg), 8'b0000010); chk("mmss_d0_an", 8'(an), 8'b1110);
        goto(202); chk("mmss_d1_seg", 8'(seg), 8'b0010010);

        // Asynchronous reset in the middle of the d2 dwell
        goto(210);
        #1 reset = 1'b1;
        #1;
        chk("midrst_an", 8'(an), 8'hF);
        chk("midrst_seg", 8'(seg), 8'h7F);
        chk("midrst_dp", 8'(dp), 8'h1);
        chk("midrst_mode", 8'(mode), 8'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        goto(1); chk("rst2_guard_an", 8'(an), 8'b1111);
        goto(2); chk("rst2_d0_an", 8'(an), 8'b1110); chk("rst2_d0_seg", 8'(seg), 8'b1000000);
        goto(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
